// File: rtl/pipe_pkg.sv
// Shared encodings for the MIPS pipeline: ALU op/funct codes, internal ALU
// control codes and bit positions of the WB/M control bundles.
package pipe_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_CTL_ADD = 3'd0,
    ALU_CTL_SUB = 3'd1,
    ALU_CTL_AND = 3'd2,
    ALU_CTL_OR  = 3'd3,
    ALU_CTL_SLT = 3'd4
  } alu_ctl_e;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;
  localparam int M_BRANCH      = 2;
  localparam int M_MEM_READ    = 1;
  localparam int M_MEM_WRITE   = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/signed slt, wrapping arithmetic, zero flag.
module alu
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        ctl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic slt;

  assign slt = ($signed(a_i) < $signed(b_i));

  always_comb begin
    result_o = a_i + b_i;
    case (ctl_i)
      ALU_CTL_SUB: result_o = a_i - b_i;
      ALU_CTL_AND: result_o = a_i & b_i;
      ALU_CTL_OR:  result_o = a_i | b_i;
      ALU_CTL_SLT: result_o = {{(DATA_W-1){1'b0}}, slt};
      default:     result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register: operand forwarding, ALU control decode,
// ALU, branch target and dest select, all registered with 1-cycle latency.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              flush,
  input  logic [1:0]        EX_wb,
  input  logic [2:0]        EX_m,
  input  logic              EX_reg_dst,
  input  logic [1:0]        EX_alu_op,
  input  logic              EX_alu_src,
  input  logic [DATA_W-1:0] EX_pc_plus_4,
  input  logic [DATA_W-1:0] EX_reg_data1,
  input  logic [DATA_W-1:0] EX_reg_data2,
  input  logic [DATA_W-1:0] EX_sign_ext_imm,
  input  logic [REG_AW-1:0] EX_instr_25_21,
  input  logic [REG_AW-1:0] EX_instr_20_16,
  input  logic [REG_AW-1:0] EX_instr_15_11,
  input  logic [REG_AW-1:0] MEM_fwd_rd,
  input  logic              MEM_fwd_we,
  input  logic [DATA_W-1:0] MEM_fwd_data,
  input  logic [REG_AW-1:0] WB_fwd_rd,
  input  logic              WB_fwd_we,
  input  logic [DATA_W-1:0] WB_fwd_data,
  output logic [1:0]        MEM_wb,
  output logic [2:0]        MEM_m,
  output logic [DATA_W-1:0] MEM_branch_target,
  output logic              MEM_zero,
  output logic [DATA_W-1:0] MEM_alu_result,
  output logic [DATA_W-1:0] MEM_write_data,
  output logic [REG_AW-1:0] MEM_dst_reg
);

  logic [DATA_W-1:0] op_a, op_b_fwd, op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [2:0]        alu_ctl;
  logic              mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  logic [1:0]        wb_d, wb_q;
  logic [2:0]        m_d, m_q;
  logic [DATA_W-1:0] target_d, target_q;
  logic              zero_d, zero_q;
  logic [DATA_W-1:0] result_d, result_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [REG_AW-1:0] dst_d, dst_q;

  // $0 is hard-wired zero, so a pending write to it must never be forwarded.
  assign mem_hit_a = MEM_fwd_we && (MEM_fwd_rd != '0) && (MEM_fwd_rd == EX_instr_25_21);
  assign mem_hit_b = MEM_fwd_we && (MEM_fwd_rd != '0) && (MEM_fwd_rd == EX_instr_20_16);
  assign wb_hit_a  = WB_fwd_we  && (WB_fwd_rd  != '0) && (WB_fwd_rd  == EX_instr_25_21);
  assign wb_hit_b  = WB_fwd_we  && (WB_fwd_rd  != '0) && (WB_fwd_rd  == EX_instr_20_16);

  assign op_a     = mem_hit_a ? MEM_fwd_data : (wb_hit_a ? WB_fwd_data : EX_reg_data1);
  assign op_b_fwd = mem_hit_b ? MEM_fwd_data : (wb_hit_b ? WB_fwd_data : EX_reg_data2);
  assign op_b     = EX_alu_src ? EX_sign_ext_imm : op_b_fwd;

  always_comb begin
    alu_ctl = ALU_CTL_ADD;
    case (EX_alu_op)
      ALU_OP_SUB: alu_ctl = ALU_CTL_SUB;
      ALU_OP_RTYPE: begin
        case (EX_sign_ext_imm[5:0])
          FUNCT_SUB: alu_ctl = ALU_CTL_SUB;
          FUNCT_AND: alu_ctl = ALU_CTL_AND;
          FUNCT_OR:  alu_ctl = ALU_CTL_OR;
          FUNCT_SLT: alu_ctl = ALU_CTL_SLT;
          default:   alu_ctl = ALU_CTL_ADD;
        endcase
      end
      default: alu_ctl = ALU_CTL_ADD;
    endcase
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .ctl_i    (alu_ctl),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // A flushed slot keeps its datapath values; only the control bundles bubble.
  always_comb begin
    wb_d     = flush ? 2'b00 : EX_wb;
    m_d      = flush ? 3'b000 : EX_m;
    target_d = EX_pc_plus_4 + (EX_sign_ext_imm << 2);
    zero_d   = alu_zero;
    result_d = alu_result;
    wdata_d  = op_b_fwd;
    dst_d    = EX_reg_dst ? EX_instr_15_11 : EX_instr_20_16;
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      wb_q     <= '0;
      m_q      <= '0;
      target_q <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      wdata_q  <= '0;
      dst_q    <= '0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      target_q <= target_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      dst_q    <= dst_d;
    end
  end

  assign MEM_wb            = wb_q;
  assign MEM_m             = m_q;
  assign MEM_branch_target = target_q;
  assign MEM_zero          = zero_q;
  assign MEM_alu_result    = result_q;
  assign MEM_write_data    = wdata_q;
  assign MEM_dst_reg       = dst_q;

endmodule
